// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU operation codes, instruction classes and the bundled control word.
package multicycle_control_unit_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [7:0] OP_AND = 8'h00;
    localparam logic [7:0] OP_OR  = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h02;
    localparam logic [7:0] OP_SUB = 8'h06;
    localparam logic [7:0] OP_SLT = 8'h07;
    localparam logic [7:0] OP_LW  = 8'h08;
    localparam logic [7:0] OP_SW  = 8'h0A;
    localparam logic [7:0] OP_BNE = 8'h0E;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [2:0] {
        C_R   = 3'd0,
        C_LW  = 3'd1,
        C_SW  = 3'd2,
        C_BNE = 3'd3,
        C_ILL = 3'd4
    } iclass_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic       illegal;
        logic [2:0] alu;
    } ctrl_t;

endpackage

// File: rtl/mcu_decode.sv
// Combinational opcode decoder: instruction class plus the ALU code EXEC uses.
module mcu_decode
    import multicycle_control_unit_pkg::*;
#(
    parameter int OPCODE_W = 5
) (
    input  logic [OPCODE_W-1:0] opc_i,
    output iclass_t             cls_o,
    output logic [2:0]          alu_o
);

    always_comb begin
        cls_o = C_ILL;
        alu_o = ALU_AND;
        case (opc_i)
            OPCODE_W'(OP_ADD): begin cls_o = C_R;   alu_o = ALU_ADD; end
            OPCODE_W'(OP_SUB): begin cls_o = C_R;   alu_o = ALU_SUB; end
            OPCODE_W'(OP_AND): begin cls_o = C_R;   alu_o = ALU_AND; end
            OPCODE_W'(OP_OR):  begin cls_o = C_R;   alu_o = ALU_OR;  end
            OPCODE_W'(OP_SLT): begin cls_o = C_R;   alu_o = ALU_SLT; end
            // memory ops compute base+offset, BNE compares by subtraction
            OPCODE_W'(OP_LW):  begin cls_o = C_LW;  alu_o = ALU_ADD; end
            OPCODE_W'(OP_SW):  begin cls_o = C_SW;  alu_o = ALU_ADD; end
            OPCODE_W'(OP_BNE): begin cls_o = C_BNE; alu_o = ALU_SUB; end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM control unit: FETCH/DECODE/EXEC/MEM/WB with memory
// handshake stalls, illegal-opcode pulse and a retired-instruction counter.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                Branch,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemToReg,
    output logic                ALUsrc,
    output logic                RegWrite,
    output logic [ALUOP_W-1:0]  ALUop,
    output logic                illegal,
    output logic [2:0]          state,
    output logic [CNT_W-1:0]    retired
);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] opc_q;
    logic [CNT_W-1:0]    retired_q;
    logic [OPCODE_W-1:0] dec_opc;
    iclass_t             cls;
    logic [2:0]          dec_alu;
    ctrl_t               ctl, ctl_out;
    logic                retire;

    // DECODE judges legality on the live opcode, later states on the latch
    assign dec_opc = (state_q == S_DECODE) ? opcode : opc_q;

    mcu_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opc_i (dec_opc),
        .cls_o (cls),
        .alu_o (dec_alu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            opc_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) opc_q <= opcode;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ctl     = '0;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read = 1'b1;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    ctl.alu      = ALU_ADD;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cls == C_ILL) begin
                    ctl.illegal = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ctl.alu = dec_alu;
                case (cls)
                    C_R:       state_d = S_WB;
                    C_LW, C_SW: begin
                        ctl.alu_src = 1'b1;
                        state_d     = S_MEM;
                    end
                    C_BNE: begin
                        ctl.branch   = 1'b1;
                        ctl.pc_write = 1'b1;
                        retire       = 1'b1;
                        state_d      = S_FETCH;
                    end
                    default: begin
                        ctl.alu = ALU_AND;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (cls == C_LW) begin
                    ctl.mem_read = 1'b1;
                    if (mem_ready) state_d = S_WB;
                end else if (cls == C_SW) begin
                    ctl.mem_write = 1'b1;
                    ctl.alu_src   = 1'b1;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                if (cls == C_R) begin
                    ctl.reg_write = 1'b1;
                    ctl.reg_dst   = 1'b1;
                    retire        = 1'b1;
                end else if (cls == C_LW) begin
                    ctl.reg_write  = 1'b1;
                    ctl.mem_to_reg = 1'b1;
                    retire         = 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // outputs are forced quiet while reset is held, independent of the clock
    assign ctl_out  = rst ? '0 : ctl;
    assign PCWrite  = ctl_out.pc_write;
    assign IRWrite  = ctl_out.ir_write;
    assign RegDst   = ctl_out.reg_dst;
    assign Branch   = ctl_out.branch;
    assign MemRead  = ctl_out.mem_read;
    assign MemWrite = ctl_out.mem_write;
    assign MemToReg = ctl_out.mem_to_reg;
    assign ALUsrc   = ctl_out.alu_src;
    assign RegWrite = ctl_out.reg_write;
    assign illegal  = ctl_out.illegal;
    assign ALUop    = ALUOP_W'(ctl_out.alu);
    assign state    = state_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction timeline model vs. the control unit.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ready;
    logic [4:0] opcode;

    logic pcw, irw, rd, br, mrd, mwr, m2r, asrc, rw, ill;
    logic [2:0]  aluop, st;
    logic [15:0] ret;
    logic pcw2, irw2, rd2, br2, mrd2, mwr2, m2r2, asrc2, rw2, ill2;
    logic [2:0]  aluop2, st2;
    logic [1:0]  ret2;

    multicycle_control_unit u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(pcw), .IRWrite(irw), .RegDst(rd), .Branch(br),
        .MemRead(mrd), .MemWrite(mwr), .MemToReg(m2r), .ALUsrc(asrc),
        .RegWrite(rw), .ALUop(aluop), .illegal(ill), .state(st), .retired(ret)
    );

    multicycle_control_unit #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(pcw2), .IRWrite(irw2), .RegDst(rd2), .Branch(br2),
        .MemRead(mrd2), .MemWrite(mwr2), .MemToReg(m2r2), .ALUsrc(asrc2),
        .RegWrite(rw2), .ALUop(aluop2), .illegal(ill2), .state(st2), .retired(ret2)
    );

    always #5 clk = ~clk;

    localparam logic [12:0] K_PCW  = 13'h1000;
    localparam logic [12:0] K_IRW  = 13'h0800;
    localparam logic [12:0] K_RD   = 13'h0400;
    localparam logic [12:0] K_BR   = 13'h0200;
    localparam logic [12:0] K_MRD  = 13'h0100;
    localparam logic [12:0] K_MWR  = 13'h0080;
    localparam logic [12:0] K_M2R  = 13'h0040;
    localparam logic [12:0] K_ASRC = 13'h0020;
    localparam logic [12:0] K_RW   = 13'h0010;
    localparam logic [12:0] K_ILL  = 13'h0008;

    typedef struct {
        logic [2:0]  st;
        logic        mr;
        logic [4:0]  opc;
        logic [12:0] ctl;
        bit          ret;
    } ent_t;

    ent_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] s, input logic mr, input logic [12:0] c,
                        input bit r, input logic [4:0] o);
        ent_t e;
        e.st = s; e.mr = mr; e.ctl = c; e.ret = r; e.opc = o;
        q.push_back(e);
    endtask

    // cls: 0=R 1=LW 2=SW 3=BNE 4=illegal
    task automatic classify(input logic [4:0] o, output int cls, output logic [2:0] alu);
        alu = 3'd0;
        case (o)
            5'h02: begin cls = 0; alu = 3'd3; end
            5'h06: begin cls = 0; alu = 3'd4; end
            5'h00: begin cls = 0; alu = 3'd0; end
            5'h01: begin cls = 0; alu = 3'd1; end
            5'h07: begin cls = 0; alu = 3'd5; end
            5'h08: cls = 1;
            5'h0A: cls = 2;
            5'h0E: cls = 3;
            default: cls = 4;
        endcase
    endtask

    function automatic logic rmr();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [4:0] ropc();
        return 5'($urandom);
    endfunction

    // Expected per-cycle timeline of one instruction; fw/mw are memory stall cycles.
    task automatic build(input logic [4:0] o, input int fw, input int mw);
        int cls;
        logic [2:0] alu;
        for (int i = 0; i < fw; i++) push(3'd0, 1'b0, K_MRD, 0, ropc());
        push(3'd0, 1'b1, K_MRD | K_IRW | K_PCW | 13'd3, 0, ropc());
        classify(o, cls, alu);
        push(3'd1, rmr(), (cls == 4) ? K_ILL : 13'd0, 0, o);
        case (cls)
            0: begin
                push(3'd2, rmr(), {10'd0, alu}, 0, ropc());
                push(3'd4, rmr(), K_RW | K_RD, 1, ropc());
            end
            1: begin
                push(3'd2, rmr(), K_ASRC | 13'd3, 0, ropc());
                for (int i = 0; i < mw; i++) push(3'd3, 1'b0, K_MRD, 0, ropc());
                push(3'd3, 1'b1, K_MRD, 0, ropc());
                push(3'd4, rmr(), K_RW | K_M2R, 1, ropc());
            end
            2: begin
                push(3'd2, rmr(), K_ASRC | 13'd3, 0, ropc());
                for (int i = 0; i < mw; i++) push(3'd3, 1'b0, K_MWR | K_ASRC, 0, ropc());
                push(3'd3, 1'b1, K_MWR | K_ASRC, 1, ropc());
            end
            3: push(3'd2, rmr(), K_BR | K_PCW | 13'd4, 1, ropc());
            default: ;
        endcase
    endtask

    task automatic run_n(input int n);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) break;
            e = q.pop_front();
            @(negedge clk);
            opcode    = e.opc;
            mem_ready = e.mr;
            #1;
            chk("state", 32'(st), 32'(e.st));
            chk("ctl", 32'({pcw, irw, rd, br, mrd, mwr, m2r, asrc, rw, ill, aluop}), 32'(e.ctl));
            chk("retired", 32'(ret), 32'(cnt % 65536));
            chk("retired_w2", 32'(ret2), 32'(cnt % 4));
            chk("rd_wr_excl", 32'(mrd & mwr), 32'd0);
            if (e.ret) cnt++;
        end
    endtask

    task automatic run_all();
        run_n(q.size());
    endtask

    // one extra FETCH-stall cycle, used for literal checks between instructions
    task automatic idle_chk();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("idle_state", 32'(st), 32'd0);
        chk("idle_ctl", 32'({pcw, irw, rd, br, mrd, mwr, m2r, asrc, rw, ill, aluop}), 32'(K_MRD));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_ctl", 32'({pcw, irw, rd, br, mrd, mwr, m2r, asrc, rw, ill, aluop}), 32'd0);
        chk("rst_retired", 32'(ret), 32'd0);
        chk("rst_retired_w2", 32'(ret2), 32'd0);
        q.delete();
        cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_fetch", 32'({pcw, irw, rd, br, mrd, mwr, m2r, asrc, rw, ill, aluop}), 32'(K_MRD));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] legal [8];
        int lit [5];
        logic [4:0] o;
        legal = '{5'h02, 5'h06, 5'h00, 5'h01, 5'h07, 5'h08, 5'h0A, 5'h0E};
        lit   = '{1, 2, 3, 0, 1};
        rst = 1'b1; mem_ready = 1'b0; opcode = 5'd0;
        #12;
        chk("init_state", 32'(st), 32'd0);
        chk("init_ctl", 32'({pcw, irw, rd, br, mrd, mwr, m2r, asrc, rw, ill, aluop}), 32'd0);
        chk("init_retired", 32'(ret), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        build(5'h02, 0, 0);
        chk("add_len", 32'(q.size()), 32'd4);
        run_all();
        idle_chk();
        chk("add_retired", 32'(ret), 32'd1);

        build(5'h08, 0, 2);
        chk("lw_len", 32'(q.size()), 32'd7);
        run_all();
        idle_chk();
        chk("lw_retired", 32'(ret), 32'd2);

        build(5'h0A, 0, 0);
        chk("sw_len", 32'(q.size()), 32'd4);
        build(5'h0E, 0, 0);
        chk("sw_bne_len", 32'(q.size()), 32'd7);
        run_all();
        idle_chk();
        chk("sw_bne_retired", 32'(ret), 32'd4);

        build(5'h1F, 0, 0);
        chk("ill_len", 32'(q.size()), 32'd2);
        run_all();
        idle_chk();
        chk("ill_retired", 32'(ret), 32'd4);

        // reset asserted while the FSM sits in EXEC
        build(5'h02, 0, 0);
        run_n(2);
        do_reset();

        for (int k = 0; k < 5; k++) begin
            build(5'h02, $urandom_range(0, 2), 0);
            run_all();
            idle_chk();
            chk("w2_seq", 32'(ret2), 32'(lit[k]));
        end

        // reset during a LW memory stall abandons the access
        build(5'h08, 0, 3);
        run_n(4);
        do_reset();
        build(5'h06, 0, 0);
        run_all();
        idle_chk();
        chk("after_mem_rst", 32'(ret), 32'd1);
        cnt = 1;

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) o = 5'($urandom);
            else o = legal[$urandom_range(0, 7)];
            build(o, $urandom_range(0, 2), $urandom_range(0, 2));
            run_all();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OPCODE_W, default 5: opcode field width, at least 4.
REQ-002 Parameter ALUOP_W, default 3: ALU operation code width, at least 3.
REQ-003 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 opcode  in  OPCODE_W  instruction opcode; valid from the cycle after IRWrite.
REQ-007 mem_ready  in  1  memory handshake; access completes in a cycle with MemRead/MemWrite=1 and mem_ready=1.
REQ-008 PCWrite, IRWrite  out  1  PC update / instruction-register load strobes.
REQ-009 RegDst, Branch, MemRead, MemWrite, MemToReg, ALUsrc, RegWrite  out  1  datapath controls.
REQ-010 ALUop  out  ALUOP_W  ALU operation; 3-bit codes zero-extended.
REQ-011 illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-012 state  out  3  current state encoding, for debug.
REQ-013 retired  out  CNT_W  count of completed legal instructions.

Function
REQ-014 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 unreachable, recover to FETCH next cycle.
REQ-015 Every output not listed as asserted in a state is 0; ALUop=000 unless stated.
REQ-016 FETCH: MemRead=1. When mem_ready=1: IRWrite=1, PCWrite=1, ALUop=011, go to DECODE. Otherwise hold FETCH with all other outputs 0.
REQ-017 DECODE: register opcode into an internal latch and go to EXEC; opcode changes after DECODE have no effect until the next DECODE.
REQ-018 Supported opcodes: ADD=h2 (ALUop 011), SUB=h6 (100), AND=h0 (000), OR=h1 (001), SLT=h7 (101), LW=h8, SW=hA, BNE=hE.
REQ-019 Any other opcode in DECODE: illegal=1 for one cycle, next state FETCH, retired unchanged.
REQ-020 EXEC, R-type (ADD/SUB/AND/OR/SLT): ALUsrc=0, ALUop per REQ-018, go to WB.
REQ-021 EXEC, LW/SW: ALUsrc=1, ALUop=011, go to MEM.
REQ-022 EXEC, BNE: Branch=1, ALUop=100; PCWrite=1 in the same cycle; go to FETCH; retire.
REQ-023 MEM, LW: MemRead=1; on mem_ready=1 go to WB, else hold.
REQ-024 MEM, SW: MemWrite=1, ALUsrc=1; on mem_ready=1 go to FETCH and retire, else hold.
REQ-025 WB, R-type: RegWrite=1, RegDst=1, go to FETCH, retire.
REQ-026 WB, LW: RegWrite=1, MemToReg=1, RegDst=0, go to FETCH, retire.
REQ-027 Latency with mem_ready held at 1: R-type 4 cycles, LW 5, SW 4, BNE 3; each wait cycle adds 1.
REQ-028 "Retire" means retired increments by 1 on leaving the final state; it wraps from all-ones to 0.
REQ-029 MemRead and MemWrite are never both 1 in the same cycle.

Reset
REQ-030 While rst=1: state=FETCH, latched opcode=0, retired=0, illegal=0, all strobes 0, regardless of clk.
REQ-031 Reset may assert in any state, including a MEM wait; the pending access is abandoned with no RegWrite or retire.
REQ-032 The first rising edge after rst falls evaluates FETCH normally.

Structure
REQ-033 The shared package holds: state encodings, opcode constants for the eight instructions, ALUop constants (AND 000, OR 001, ADD 011, SUB 100, SLT 101).
REQ-034 One sub-module, mcu_decode: a combinational map from latched opcode to instruction class (R, LW, SW, BNE, illegal) and ALUop.

Verification
REQ-035 rst pulse mid-EXEC -> outputs 0, state=0 immediately, with no clock edge required; retired=0.
REQ-036 ADD (h2), mem_ready=1 -> IRWrite at cycle 0, ALUop=011 at cycle 2, RegWrite=RegDst=1 at cycle 3, retired=1.
REQ-037 LW (h8), mem_ready low for 2 MEM cycles -> MemRead held 3 cycles, MemToReg=RegWrite=1 next, total 7 cycles.
REQ-038 SW (hA) then BNE (hE) -> MemWrite only in MEM, Branch=PCWrite=1 at BNE cycle 2, retired=2.
REQ-039 Opcode h1F -> illegal pulse in DECODE, back to FETCH, retired unchanged, no RegWrite or MemWrite.
REQ-040 CNT_W=2, 5 ADDs -> retired sequence 1,2,3,0,1.
